// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the integer register file write port between core writeback and a
// buffered photon coprocessor write stream, with forced drain and pending-hit flags.
module regfile_wr_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned DATA_W       = 32
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              core_we,
    input  logic [4:0]        core_rd,
    input  logic [DATA_W-1:0] core_data,
    input  logic              mem_hold,
    input  logic              ph_we,
    input  logic [4:0]        ph_rd,
    input  logic [DATA_W-1:0] ph_data,
    output logic              ph_ready,
    output logic              core_stall,
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    output logic              rs1_pend,
    output logic              rs2_pend,
    output logic              rf_we,
    output logic [4:0]        rf_addr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        ST_NORMAL,
        ST_DRAIN
    } state_t;

    state_t state, state_n;

    logic [4:0]            rd_q   [FIFO_DEPTH];
    logic [DATA_W-1:0]     data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] valid_q;
    logic [AW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         count, count_n;
    logic [SW-1:0]         starve, starve_n;

    logic              core_acc;
    logic              ph_acc;
    logic              enq;
    logic              deq;
    logic              issue_we;
    logic [4:0]        issue_addr;
    logic [DATA_W-1:0] issue_data;

    assign ph_ready = (count < DEPTH_C);

    always_comb begin
        core_acc   = core_we && (core_rd != 5'd0) && !mem_hold && !core_stall
                     && (state == ST_NORMAL);
        ph_acc     = ph_we && ph_ready;
        enq        = ph_acc && (ph_rd != 5'd0);
        deq        = 1'b0;
        starve_n   = starve;
        state_n    = state;
        issue_we   = 1'b0;
        issue_addr = '0;
        issue_data = '0;

        case (state)
            ST_NORMAL: begin
                if (core_acc) begin
                    if (count != '0) begin
                        starve_n = starve + SW'(1);
                    end
                end else if (count != '0) begin
                    deq      = 1'b1;
                    starve_n = '0;
                end else begin
                    starve_n = '0;
                end
            end
            ST_DRAIN: begin
                deq      = (count != '0);
                starve_n = '0;
            end
            default: begin
                state_n = ST_NORMAL;
            end
        endcase

        count_n = count + CW'(enq) - CW'(deq);

        // Transitions judged on end-of-cycle occupancy and starvation.
        if (state == ST_NORMAL) begin
            if ((starve_n >= STARVE_C) || (count_n == DEPTH_C)) begin
                state_n = ST_DRAIN;
            end
        end else if (state == ST_DRAIN) begin
            if (count_n == '0) begin
                state_n = ST_NORMAL;
            end
        end

        if (core_acc) begin
            issue_we   = 1'b1;
            issue_addr = core_rd;
            issue_data = core_data;
        end else if (deq && valid_q[rd_ptr]) begin
            issue_we   = 1'b1;
            issue_addr = rd_q[rd_ptr];
            issue_data = data_q[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state      <= ST_NORMAL;
            count      <= '0;
            starve     <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            valid_q    <= '0;
            core_stall <= 1'b0;
            rf_we      <= 1'b0;
            rf_addr    <= '0;
            rf_wdata   <= '0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            starve     <= starve_n;
            core_stall <= (state_n == ST_DRAIN);
            rf_we      <= issue_we;
            rf_addr    <= issue_addr;
            rf_wdata   <= issue_data;

            if (deq) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + AW'(1);
            end
            // Core value is newer than buffered ones; a same-cycle enqueue below overrides.
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                if (core_acc && (rd_q[AW'(i)] == core_rd)) begin
                    valid_q[AW'(i)] <= 1'b0;
                end
            end
            if (enq) begin
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            rd_q[wr_ptr]   <= ph_rd;
            data_q[wr_ptr] <= ph_data;
        end
    end

    always_comb begin
        rs1_pend = 1'b0;
        rs2_pend = 1'b0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (valid_q[AW'(i)]) begin
                if ((rd_q[AW'(i)] == rs1_addr) && (rs1_addr != 5'd0)) begin
                    rs1_pend = 1'b1;
                end
                if ((rd_q[AW'(i)] == rs2_addr) && (rs2_addr != 5'd0)) begin
                    rs2_pend = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: hand-computed expectations checked
// with immediate assertions one cycle after each decision.
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        Rst;
    logic        core_we;
    logic [4:0]  core_rd;
    logic [31:0] core_data;
    logic        mem_hold;
    logic        ph_we;
    logic [4:0]  ph_rd;
    logic [31:0] ph_data;
    logic        ph_ready;
    logic        core_stall;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_pend;
    logic        rs2_pend;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;

    int vectors     = 0;
    int miscompares = 0;

    regfile_wr_arbiter #(
        .FIFO_DEPTH  (4),
        .STARVE_LIMIT(8),
        .DATA_W      (32)
    ) dut (
        .clk       (clk),
        .Rst       (Rst),
        .core_we   (core_we),
        .core_rd   (core_rd),
        .core_data (core_data),
        .mem_hold  (mem_hold),
        .ph_we     (ph_we),
        .ph_rd     (ph_rd),
        .ph_data   (ph_data),
        .ph_ready  (ph_ready),
        .core_stall(core_stall),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_pend  (rs1_pend),
        .rs2_pend  (rs2_pend),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_we   = 1'b0;
        core_rd   = 5'd0;
        core_data = 32'd0;
        mem_hold  = 1'b0;
        ph_we     = 1'b0;
        ph_rd     = 5'd0;
        ph_data   = 32'd0;
    endtask

    task automatic check_wr(input string tag, input logic [4:0] addr, input logic [31:0] data);
        check({tag, "_we"},   rf_we,    1);
        check({tag, "_addr"}, rf_addr,  addr);
        check({tag, "_data"}, rf_wdata, data);
    endtask

    initial begin
        Rst      = 1'b1;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        idle();
        tick();
        tick();
        check("rst_rf_we",    rf_we,      0);
        check("rst_rf_addr",  rf_addr,    0);
        check("rst_rf_wdata", rf_wdata,   0);
        check("rst_stall",    core_stall, 0);
        check("rst_ph_ready", ph_ready,   1);
        check("rst_pend",     rs1_pend,   0);
        Rst = 1'b0;

        // Core write x5 issues one cycle later; mem_hold blocks it.
        core_we = 1'b1; core_rd = 5'd5; core_data = 32'hA5;
        tick();
        core_we = 1'b0;
        check_wr("core_x5", 5'd5, 32'hA5);
        core_we = 1'b1; mem_hold = 1'b1;
        tick();
        idle();
        check("hold_rf_we", rf_we, 0);

        // Photon x3 then x4 with idle core drain in order.
        rs1_addr = 5'd4;
        ph_we = 1'b1; ph_rd = 5'd3; ph_data = 32'h11;
        tick();
        check("ph_enq_rf_we", rf_we,    0);
        check("ph_enq_pend0", rs1_pend, 0);
        ph_rd = 5'd4; ph_data = 32'h22;
        tick();
        idle();
        check_wr("ph_x3", 5'd3, 32'h11);
        check("ph_x4_pend1", rs1_pend, 1);
        tick();
        check_wr("ph_x4", 5'd4, 32'h22);
        check("ph_x4_pend0", rs1_pend, 0);
        tick();
        check("ph_done_rf_we", rf_we, 0);

        // Buffered x7 killed by core writes; starvation forces a drain.
        rs1_addr = 5'd0;
        rs2_addr = 5'd7;
        ph_we = 1'b1; ph_rd = 5'd7; ph_data = 32'h33;
        tick();
        idle();
        check("x7_pend", rs2_pend, 1);
        core_we = 1'b1; core_rd = 5'd7; core_data = 32'h44;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_wr("core_x7", 5'd7, 32'h44);
            check("x7_killed_pend", rs2_pend, 0);
            check("starve_stall", core_stall, (k == 7));
        end
        idle();
        tick();
        check("killed_deq_rf_we", rf_we,      0);
        check("starve_exit",      core_stall, 0);
        tick();
        check("after_kill_rf_we", rf_we, 0);

        // FIFO fills under continuous core writes, then a 4-cycle drain.
        rs2_addr = 5'd0;
        for (int k = 1; k <= 4; k++) begin
            core_we = 1'b1; core_rd = 5'd9; core_data = 32'(k);
            ph_we = 1'b1; ph_rd = 5'(10 + k); ph_data = 32'h100 + 32'(k);
            tick();
            check_wr("fill_core", 5'd9, 32'(k));
            check("fill_stall", core_stall, (k == 4));
            check("fill_ready", ph_ready,   (k < 4));
        end
        ph_we = 1'b0; core_data = 32'hEE;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_wr("drain", 5'(10 + k), 32'h100 + 32'(k));
            check("drain_stall", core_stall, (k < 4));
            check("drain_ready", ph_ready,   1);
        end
        tick();
        idle();
        check_wr("post_drain_core", 5'd9, 32'hEE);
        tick();
        check("post_drain_idle", rf_we, 0);

        // x0 writes from both sides are dropped.
        core_we = 1'b1; core_rd = 5'd0; core_data = 32'h66;
        ph_we = 1'b1; ph_rd = 5'd0; ph_data = 32'h55;
        tick();
        idle();
        check("x0_rf_we",   rf_we,    0);
        check("x0_ready",   ph_ready, 1);
        check("x0_pend",    rs1_pend, 0);
        tick();
        check("x0_no_enq",  rf_we,    0);

        // Same-cycle core and photon write to x12: photon value is newer.
        rs1_addr = 5'd12;
        core_we = 1'b1; core_rd = 5'd12; core_data = 32'h77;
        ph_we = 1'b1; ph_rd = 5'd12; ph_data = 32'h88;
        tick();
        idle();
        check_wr("same_core", 5'd12, 32'h77);
        check("same_pend1", rs1_pend, 1);
        tick();
        check_wr("same_ph", 5'd12, 32'h88);
        check("same_pend0", rs1_pend, 0);

        // Reset with three buffered entries discards them.
        rs1_addr = 5'd22;
        rs2_addr = 5'd20;
        for (int k = 0; k < 3; k++) begin
            core_we = 1'b1; core_rd = 5'd1; core_data = 32'd0;
            ph_we = 1'b1; ph_rd = 5'(20 + k); ph_data = 32'(k);
            tick();
        end
        idle();
        check("pre_rst_pend1", rs1_pend, 1);
        check("pre_rst_pend2", rs2_pend, 1);
        check("pre_rst_ready", ph_ready, 1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("mid_rst_rf_we", rf_we,      0);
        check("mid_rst_stall", core_stall, 0);
        check("mid_rst_pend1", rs1_pend,   0);
        check("mid_rst_pend2", rs2_pend,   0);
        check("mid_rst_ready", ph_ready,   1);
        tick();
        check("mid_rst_no_drain", rf_we, 0);
        tick();
        check("mid_rst_still_idle", rf_we, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the integer register file's single write port between two requesters: the core MEM/WB writeback and the photon coprocessor.
- Core writes win by default. Photon writes are buffered in a small FIFO and drained on idle write-port cycles.
- A starvation/full condition forces a drain phase, during which the core pipeline is stalled.
- Provides pending-write hit flags so the decode stage can stall reads of registers with a buffered photon write.

Parameters:
- FIFO_DEPTH, 4, photon write buffer entries (power of two, >=2).
- STARVE_LIMIT, 8, cycles a non-empty FIFO may go undrained before a forced drain.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset; synchronous, active-high.
- core_we  in  1  core writeback request (MEM_WB regwrite).
- core_rd  in  5  core destination register.
- core_data  in  DATA_W  core writeback value.
- mem_hold  in  1  memory hold; when high, core write is not accepted.
- ph_we  in  1  photon write valid.
- ph_rd  in  5  photon destination register.
- ph_data  in  DATA_W  photon write value.
- ph_ready  out  1  photon write accepted this cycle when ph_we && ph_ready.
- core_stall  out  1  forced-drain stall to the core pipeline.
- rs1_addr, rs2_addr  in  5 each  decode read addresses.
- rs1_pend, rs2_pend  out  1 each  a valid buffered photon write targets that address (never for x0).
- rf_we  out  1  register file write enable.
- rf_addr  out  5  register file write address.
- rf_wdata  out  DATA_W  register file write data.

Behaviour:
- Reset (synchronous, high for >=1 cycle):
  - FIFO emptied, all entries invalid, starve counter = 0, state NORMAL.
  - Registered outputs reset to 0: rf_we, rf_addr, rf_wdata, core_stall.
  - ph_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards buffered writes; nothing is written to the register file.
- Write issue and latency:
  - rf_* are registered: a write is issued on the register-file port one cycle after the decision cycle.
  - At most one write per cycle.
- Core acceptance: core_acc = core_we && |core_rd && !mem_hold && !core_stall.
  - Writes to x0 are dropped, never issued.
- Photon acceptance:
  - ph_ready = (count < FIFO_DEPTH), evaluated on the current count.
  - A dequeue in the same cycle does not free a slot early.
  - An accepted write with ph_rd == 0 is consumed but not enqueued.
- States:
  - NORMAL:
    - If core_acc, issue the core write and do not dequeue; the starve counter increments when the FIFO is non-empty.
    - Otherwise, if the FIFO is non-empty, dequeue the head and reset the counter to 0.
  - NORMAL -> DRAIN when the counter reaches STARVE_LIMIT, or when count == FIFO_DEPTH at a cycle end.
  - DRAIN:
    - core_stall = 1 starting the cycle after entry.
    - Dequeue the head every cycle; core_we is ignored.
  - DRAIN -> NORMAL when the FIFO becomes empty. core_stall drops the following cycle and the counter clears.
- Dequeue: the head is issued on rf_* only if its valid bit is set. Killed entries consume the dequeue cycle with rf_we = 0.
- Coherence:
  - A core write accepted to rd invalidates every buffered entry with the same rd, because the core value is newer.
  - A photon enqueue in the same cycle as a core write to the same rd is treated as newer: it is enqueued valid.
- Pending flags: rsN_pend = OR over valid entries of (entry.rd == rsN_addr && rsN_addr != 0). Combinational from current FIFO state.
- Wrap-around: read/write pointers are mod FIFO_DEPTH. count ranges 0..FIFO_DEPTH.

Test Plan:
- Reset, then core_we=1, rd=5, data=0xA5 with mem_hold=0 -> next cycle rf_we=1, rf_addr=5, rf_wdata=0xA5. Same request with mem_hold=1 -> rf_we=0.
- Photon writes x3=0x11 and x4=0x22 while core idle -> issued in order on consecutive cycles. rs1_addr=4 -> rs1_pend=1 until the x4 entry dequeues.
- Photon enqueues x7=0x33, then core writes x7=0x44 every cycle for 8 cycles -> entry killed, x7 final value 0x44, no photon write to x7 issued.
- Continuous core writes while 4 photon writes are enqueued -> FIFO full, ph_ready=0, core_stall=1 for 4 drain cycles, then ph_ready=1 and core_stall=0.
- Photon write to x0 and core write to x0 -> no rf_we, no enqueue, count unchanged.
- Rst asserted with 3 buffered entries -> next cycle count=0, rf_we=0, core_stall=0, rs*_pend=0.
